cb_ctx: RTL
===========

# cb_ctx

Multi-context connection block with an integrated serial configuration loader, for fabric tiles that need runtime reconfiguration. It routes between two adjacent CLBs and two single-length track bundles, like the existing connection block. It holds `NUM_CTX` independent configuration banks, one of which drives the routing muxes at a time. Banks are reprogrammed atomically through the daisy-chained ID-addressed config stream while another bank stays live.

## Interface
Parameters:
- `CLB_IWIDTH`, 10: inputs per CLB
- `CLB_OWIDTH`, 4: outputs per CLB
- `CHN_WIDTH`, 16: tracks per single bundle
- `NUM_CTX`, 2: number of config banks, at least 1
- `ID_WIDTH`, 3: config address width
- `ID`, 7: this block's config address

Ports:
- `clk` in 1: single clock for fabric and config
- `crst` in 1: reset, synchronous, active-high
- `clb0_output`, `clb1_output` in `CLB_OWIDTH`: CLB outputs (0 = same tile, 1 = adjacent)
- `clb0_input`, `clb1_input` out `CLB_IWIDTH`: CLB input drivers
- `single0_in`, `single1_in` in `CHN_WIDTH`: track inputs
- `single0_out`, `single1_out` out `CHN_WIDTH`: track drivers
- `ctx_sel` in `CW`: requested context; `CW = max(1, clog2(NUM_CTX))`
- `ctx_switch` in 1: load `ctx_sel` into the active-context register
- `active_ctx` out `CW`: current live context
- `cfg_in_start`, `cfg_bit_in` in 1: serial config frame in
- `cfg_out_start`, `cfg_bit_out` out 1: serial config frame out to the next block
- `cfg_busy` out 1: frame in progress
- `cfg_done` out 1: one-cycle pulse when a bank is committed
- `cfg_err` out 1: one-cycle pulse when a frame targets a context `>= NUM_CTX`

## Operation
**Mux field widths and layout**
- Single-output select width: `SO = clog2(CHN_WIDTH + 2*CLB_OWIDTH + 1)`.
- CLB-input select width: `CI = clog2(2*CHN_WIDTH + CLB_OWIDTH + 1)`.
- Bank layout, LSB first:
  - `single0_out` fields (`CHN_WIDTH` × `SO`)
  - `single1_out` fields (`CHN_WIDTH` × `SO`)
  - `clb0_input` fields (`CLB_IWIDTH` × `CI`)
  - `clb1_input` fields (`CLB_IWIDTH` × `CI`)
- Field `j` of a group sits at `base + j*width`.
- `CFG_SIZE` is the total, 280 at defaults.

**Mux sources**
- For `single{k}_out[j]`, select `s`:
  - 0 → constant 0
  - 1..W → `single{1-k}_in[s-1]`
  - then `clb0_output`, then `clb1_output`
  - out-of-range → 0
- For `clb{k}_input[j]`, select `s`:
  - 0 → constant 0
  - then `single0_in`, then `single1_in`, then `clb{1-k}_output`
  - out-of-range → 0
- Datapath is combinational from bank[`active_ctx`].

**Frame format**, serial, one bit per cycle: `ID` (MSB first), then target ctx (`CW` bits, MSB first), then payload (`CFG_SIZE` bits, bit 0 first). Header length `H = ID_WIDTH + CW`; frame length `F = H + CFG_SIZE`.

**FSM**
- IDLE:
  - `cfg_in_start` → HDR; that cycle's `cfg_bit_in` is header bit 0.
- HDR:
  - shifts header bits.
  - after H bits: ID match and ctx < `NUM_CTX` → LOAD.
  - ID match and ctx ≥ `NUM_CTX` → SKIP, with `cfg_err` pulsing on that transition.
  - mismatch → SKIP.
- LOAD:
  - shifts payload into a shadow register, counting `CFG_SIZE` bits.
  - then → COMMIT.
- SKIP:
  - counts the remaining `CFG_SIZE` bits, then → IDLE.
  - no bank change.
- COMMIT (1 cycle):
  - writes shadow into bank[ctx] and pulses `cfg_done`.
  - next state is IDLE, or HDR if `cfg_in_start` is high that cycle.

**Forwarding and boundary cases**
- `cfg_bit_out` and `cfg_out_start` are `cfg_bit_in` and `cfg_in_start` registered by one flop, in every state.
- `cfg_in_start` during HDR, LOAD or SKIP aborts the frame: shadow is discarded, no commit, FSM restarts in HDR with the current bit as header bit 0.
- `ctx_switch`: `active_ctx <= ctx_sel` if `ctx_sel < NUM_CTX`, otherwise ignored.
- Commit to the active bank: outputs change the cycle after COMMIT.
- Commit and `ctx_switch` in the same cycle: both take effect; the next cycle shows the new context with the new contents.

**Reset** (`crst`, synchronous)
- all banks, shadow and counters are 0; FSM is IDLE.
- `active_ctx` is 0.
- `cfg_busy`, `cfg_done`, `cfg_err`, `cfg_bit_out`, `cfg_out_start` are 0.
- all routing outputs are 0.
- `crst` mid-frame drops the frame.

## Timing
- Frame start is cycle 0. Header bits arrive in cycles 0..H-1 and payload in H..F-1.
- COMMIT occupies cycle F, with `cfg_done` high. New routing is visible from cycle F+1.
- `cfg_busy` is high in cycles 1..F for a committing frame, and 1..F-1 for a skipped frame.
- The earliest back-to-back `cfg_in_start` is cycle F.
- Config forwarding latency is 1 cycle.
- `ctx_switch` latency is 1 cycle. Route latency is 0, being combinational.

## Test plan
- **Reset:** assert `crst` 2 cycles with random inputs → all routing outputs 0, `active_ctx`=0, all cfg outputs 0.
- **Load and route:** frame with ID=7, ctx=0, `single0_out[0]` sel=1 and `clb0_input[3]` sel=2*16+2 → `cfg_done` in cycle 284. From 285, `single0_out[0]`=`single1_in[0]` and `clb0_input[3]`=`clb1_output[1]`.
- **Shadow load then switch:** load ctx 1 with all-zero selects except `single1_out[5]` sel=17 while ctx 0 is live → outputs unchanged through commit. `ctx_switch` with `ctx_sel`=1 → next cycle `single1_out[5]`=`clb0_output[0]` and all other routing outputs 0.
- **ID mismatch:** frame with ID=3 → no `cfg_done`, banks unchanged. `cfg_bit_out` equals `cfg_bit_in` delayed 1 cycle for all 284 bits.
- **Abort:** `cfg_in_start` re-asserted at payload bit 100, followed by a complete valid frame → only the second frame commits, `cfg_done` once.
- **Boundaries:** NUM_CTX=3 with target ctx=3 → `cfg_err` pulse, no commit. Back-to-back frames with the second start in the COMMIT cycle → both commit. `crst` at bit 50 → no commit.

Source files
------------

// File: rtl/cb_ctx.sv
// cb_ctx: multi-context connection block with a serial configuration loader.
//
// Routes two adjacent CLBs and two single-length track bundles through
// select-driven muxes. NUM_CTX configuration banks are held; the bank chosen
// by active_ctx drives the muxes combinationally. A daisy-chained,
// ID-addressed serial frame (ID, target ctx, payload) fills a shadow register
// that is committed to one bank in a single cycle, so a live bank is never
// seen half-written.
//
// Ports:
//   clk, crst                  clock, synchronous active-high reset
//   clb0_output, clb1_output   CLB outputs (0 = same tile, 1 = adjacent)
//   clb0_input, clb1_input     CLB input drivers
//   single0_in, single1_in     track inputs
//   single0_out, single1_out   track drivers
//   ctx_sel, ctx_switch        requested context and load strobe
//   active_ctx                 current live context
//   cfg_in_start, cfg_bit_in   serial frame in
//   cfg_out_start, cfg_bit_out serial frame forwarded to the next block
//   cfg_busy, cfg_done, cfg_err frame status
module cb_ctx #(
    parameter int CLB_IWIDTH = 10,
    parameter int CLB_OWIDTH = 4,
    parameter int CHN_WIDTH  = 16,
    parameter int NUM_CTX    = 2,
    parameter int ID_WIDTH   = 3,
    parameter int ID         = 7,
    localparam int CW        = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                  clk,
    input  logic                  crst,
    input  logic [CLB_OWIDTH-1:0] clb0_output,
    input  logic [CLB_OWIDTH-1:0] clb1_output,
    output logic [CLB_IWIDTH-1:0] clb0_input,
    output logic [CLB_IWIDTH-1:0] clb1_input,
    input  logic [CHN_WIDTH-1:0]  single0_in,
    input  logic [CHN_WIDTH-1:0]  single1_in,
    output logic [CHN_WIDTH-1:0]  single0_out,
    output logic [CHN_WIDTH-1:0]  single1_out,
    input  logic [CW-1:0]         ctx_sel,
    input  logic                  ctx_switch,
    output logic [CW-1:0]         active_ctx,
    input  logic                  cfg_in_start,
    input  logic                  cfg_bit_in,
    output logic                  cfg_out_start,
    output logic                  cfg_bit_out,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err
);

    // Mux source counts (including the constant-0 source) and select widths
    localparam int SO_LEN   = CHN_WIDTH + 2 * CLB_OWIDTH + 1;
    localparam int CI_LEN   = 2 * CHN_WIDTH + CLB_OWIDTH + 1;
    localparam int SO       = $clog2(SO_LEN);
    localparam int CI       = $clog2(CI_LEN);
    localparam int S0_BASE  = 0;
    localparam int S1_BASE  = CHN_WIDTH * SO;
    localparam int C0_BASE  = 2 * CHN_WIDTH * SO;
    localparam int C1_BASE  = C0_BASE + CLB_IWIDTH * CI;
    localparam int CFG_SIZE = C1_BASE + CLB_IWIDTH * CI;
    localparam int H        = ID_WIDTH + CW;
    localparam int CNT_MAX  = (CFG_SIZE > H) ? CFG_SIZE : H;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [ID_WIDTH-1:0] ID_W = ID_WIDTH'(ID);
    localparam logic [CW:0]         NCTX = (CW + 1)'(NUM_CTX);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SKIP   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [H-2:0]        hdr_r;
    logic [CW-1:0]       tgt_r;
    logic [CW-1:0]       active_ctx_r;
    logic [CFG_SIZE-1:0] shadow_r;
    logic [CFG_SIZE-1:0] bank_r [NUM_CTX];
    logic                cfg_bit_out_r;
    logic                cfg_out_start_r;
    logic                cfg_busy_r;
    logic                cfg_done_r;
    logic                cfg_err_r;

    logic [H-1:0]        hdr_full_s;
    logic                id_match_s;
    logic                ctx_ok_s;
    logic                hdr_last_s;
    logic                pay_last_s;
    logic                err_s;

    logic [CFG_SIZE-1:0] act_bank_s;
    logic [(2**SO)-1:0]  so0_src_s;
    logic [(2**SO)-1:0]  so1_src_s;
    logic [(2**CI)-1:0]  ci0_src_s;
    logic [(2**CI)-1:0]  ci1_src_s;

    assign active_ctx    = active_ctx_r;
    assign cfg_bit_out   = cfg_bit_out_r;
    assign cfg_out_start = cfg_out_start_r;
    assign cfg_busy      = cfg_busy_r;
    assign cfg_done      = cfg_done_r;
    assign cfg_err       = cfg_err_r;

    // Next-state decode; the header is judged on its last bit still on the wire
    always_comb begin
        state_s    = state_r;
        err_s      = 1'b0;
        hdr_full_s = {hdr_r, cfg_bit_in};
        id_match_s = (hdr_full_s[H-1:CW] == ID_W);
        ctx_ok_s   = ({1'b0, hdr_full_s[CW-1:0]} < NCTX);
        hdr_last_s = (cnt_r == CNT_W'(H - 1));
        pay_last_s = (cnt_r == CNT_W'(CFG_SIZE - 1));
        case (state_r)
            ST_IDLE: begin
                if (cfg_in_start) begin
                    state_s = ST_HDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (cfg_in_start) begin
                    state_s = ST_HDR;
                end else if (hdr_last_s) begin
                    if (id_match_s && ctx_ok_s) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_SKIP;
                        err_s   = id_match_s;
                    end
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_LOAD: begin
                if (cfg_in_start) begin
                    state_s = ST_HDR;
                end else if (pay_last_s) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SKIP: begin
                if (cfg_in_start) begin
                    state_s = ST_HDR;
                end else if (pay_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SKIP;
                end
            end
            ST_COMMIT: begin
                if (cfg_in_start) begin
                    state_s = ST_HDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Config state, shadow/bank storage, forwarding flops and active context
    always_ff @(posedge clk) begin
        if (crst) begin
            state_r         <= ST_IDLE;
            cnt_r           <= '0;
            hdr_r           <= '0;
            tgt_r           <= '0;
            active_ctx_r    <= '0;
            shadow_r        <= '0;
            cfg_bit_out_r   <= 1'b0;
            cfg_out_start_r <= 1'b0;
            cfg_busy_r      <= 1'b0;
            cfg_done_r      <= 1'b0;
            cfg_err_r       <= 1'b0;
            for (int i = 0; i < NUM_CTX; i++) begin
                bank_r[i] <= '0;
            end
        end else begin
            state_r         <= state_s;
            cfg_bit_out_r   <= cfg_bit_in;
            cfg_out_start_r <= cfg_in_start;
            cfg_busy_r      <= (state_s != ST_IDLE);
            cfg_done_r      <= (state_s == ST_COMMIT);
            cfg_err_r       <= err_s;

            // A start always restarts the header with the current bit as bit 0
            if (cfg_in_start) begin
                hdr_r <= (H - 1)'(cfg_bit_in);
                cnt_r <= CNT_W'(1);
            end else begin
                if (state_r == ST_HDR) begin
                    hdr_r <= hdr_full_s[H-2:0];
                end
                if ((state_s == state_r) && (state_r != ST_IDLE)) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= '0;
                end
            end

            if ((state_r == ST_HDR) && hdr_last_s && !cfg_in_start) begin
                tgt_r <= hdr_full_s[CW-1:0];
            end

            // Payload arrives bit 0 first, so shift in from the top
            if ((state_r == ST_LOAD) && !cfg_in_start) begin
                shadow_r <= {cfg_bit_in, shadow_r[CFG_SIZE-1:1]};
            end

            if (state_r == ST_COMMIT) begin
                bank_r[tgt_r] <= shadow_r;
            end

            if (ctx_switch && ({1'b0, ctx_sel} < NCTX)) begin
                active_ctx_r <= ctx_sel;
            end
        end
    end

    // Routing muxes; source vectors are zero-padded so out-of-range selects give 0
    always_comb begin
        act_bank_s = bank_r[active_ctx_r];
        so0_src_s  = '0;
        so1_src_s  = '0;
        ci0_src_s  = '0;
        ci1_src_s  = '0;
        so0_src_s[SO_LEN-1:0] = {clb1_output, clb0_output, single1_in, 1'b0};
        so1_src_s[SO_LEN-1:0] = {clb1_output, clb0_output, single0_in, 1'b0};
        ci0_src_s[CI_LEN-1:0] = {clb1_output, single1_in, single0_in, 1'b0};
        ci1_src_s[CI_LEN-1:0] = {clb0_output, single1_in, single0_in, 1'b0};
        single0_out = '0;
        single1_out = '0;
        clb0_input  = '0;
        clb1_input  = '0;
        for (int j = 0; j < CHN_WIDTH; j++) begin
            single0_out[j] = so0_src_s[act_bank_s[S0_BASE + j * SO +: SO]];
            single1_out[j] = so1_src_s[act_bank_s[S1_BASE + j * SO +: SO]];
        end
        for (int j = 0; j < CLB_IWIDTH; j++) begin
            clb0_input[j] = ci0_src_s[act_bank_s[C0_BASE + j * CI +: CI]];
            clb1_input[j] = ci1_src_s[act_bank_s[C1_BASE + j * CI +: CI]];
        end
    end

endmodule
